// File: rtl/exu_seq.sv
// exu_seq: multi-cycle execute-stage sequencer driving a shared combinational adder.
// Accepts one ALU op from IDU, runs it through the external adder, and hands the
// result to WBU. Add/addi/sub use one pass. Multiply is an iterative shift-add.
// Optional feature macro: EXU_SEQ_MUL_EN. When it is undefined, op 11 is reported
// as illegal with out_data = 0.
module exu_seq #(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [DATAWIDTH-1:0] in_src1,
    input  logic [DATAWIDTH-1:0] in_src2,
    input  logic [DATAWIDTH-1:0] in_imm,
    input  logic [4:0]           in_rd,
    output logic [DATAWIDTH-1:0] alu_a,
    output logic [DATAWIDTH-1:0] alu_b,
    output logic                 alu_sub,
    input  logic [DATAWIDTH-1:0] alu_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [4:0]           out_rd,
    output logic                 out_illegal
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StDone = 2'd3;
`ifdef EXU_SEQ_MUL_EN
    localparam logic [1:0] StMul  = 2'd2;
    localparam int unsigned CntW  = $clog2(DATAWIDTH);
`endif

    logic [1:0]           r_state;
    logic [1:0]           r_op;
    logic [DATAWIDTH-1:0] r_src1;
    logic [DATAWIDTH-1:0] r_opb;     // src2, or imm for addi
    logic [4:0]           r_rd;
    logic [DATAWIDTH-1:0] r_out_data;
    logic [4:0]           r_out_rd;
    logic                 r_out_illegal;
    logic                 w_accept;

`ifdef EXU_SEQ_MUL_EN
    logic [DATAWIDTH-1:0] r_acc;
    logic [DATAWIDTH-1:0] r_mcand;
    logic [DATAWIDTH-1:0] r_mplier;
    logic [CntW-1:0]      r_cnt;
    logic [DATAWIDTH-1:0] w_acc_nxt;

    // Accumulate the shifted multiplicand only when the current multiplier bit is set
    always_comb begin
        w_acc_nxt = r_mplier[0] ? alu_sum : r_acc;
    end
`endif

    assign in_ready    = rst_n && (r_state == StIdle);
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = (r_state == StDone);
    assign out_data    = r_out_data;
    assign out_rd      = r_out_rd;
    assign out_illegal = r_out_illegal;

    // Adder operand steering; idle/done and reset keep the adder inputs at zero
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sub = 1'b0;
        if (rst_n) begin
            case (r_state)
                StExec: begin
                    alu_a   = r_src1;
                    alu_b   = r_opb;
                    alu_sub = (r_op == 2'b10);
                end
`ifdef EXU_SEQ_MUL_EN
                StMul: begin
                    alu_a = r_acc;
                    alu_b = r_mcand;
                end
`endif
                default: ;
            endcase
        end
    end

    // Sequencer state, operand latches and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_op          <= 2'b00;
            r_src1        <= '0;
            r_opb         <= '0;
            r_rd          <= 5'd0;
            r_out_data    <= '0;
            r_out_rd      <= 5'd0;
            r_out_illegal <= 1'b0;
`ifdef EXU_SEQ_MUL_EN
            r_acc         <= '0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_cnt         <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op   <= in_op;
                        r_src1 <= in_src1;
                        r_opb  <= (in_op == 2'b01) ? in_imm : in_src2;
                        r_rd   <= in_rd;
                        if (in_op == 2'b11) begin
`ifdef EXU_SEQ_MUL_EN
                            r_acc    <= '0;
                            r_mcand  <= in_src1;
                            r_mplier <= in_src2;
                            r_cnt    <= '0;
                            r_state  <= StMul;
`else
                            r_out_data    <= '0;
                            r_out_rd      <= in_rd;
                            r_out_illegal <= 1'b1;
                            r_state       <= StDone;
`endif
                        end else begin
                            r_state <= StExec;
                        end
                    end
                end
                StExec: begin
                    r_out_data    <= alu_sum;
                    r_out_rd      <= r_rd;
                    r_out_illegal <= 1'b0;
                    r_state       <= StDone;
                end
`ifdef EXU_SEQ_MUL_EN
                StMul: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // Always DATAWIDTH iterations; no early exit on a zero multiplier
                    if (r_cnt == CntW'(DATAWIDTH - 1)) begin
                        r_out_data    <= w_acc_nxt;
                        r_out_rd      <= r_rd;
                        r_out_illegal <= 1'b0;
                        r_state       <= StDone;
                    end
                end
`endif
                StDone: begin
                    if (out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_seq.sv
// Directed bench for exu_seq with a behavioural universal_adder model.
// Covers the EXU_SEQ_MUL_EN build when that macro is defined.
module tb_exu_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_src1, in_src2, in_imm;
    logic [4:0]   in_rd;
    logic [W-1:0] alu_a, alu_b, alu_sum;
    logic         alu_sub;
    logic         out_valid, out_ready, out_illegal;
    logic [W-1:0] out_data;
    logic [4:0]   out_rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Shared adder: a + b, or a + ~b + 1 when subtracting
    assign alu_sum = alu_sub ? (alu_a + ~alu_b + 32'd1) : (alu_a + alu_b);

    exu_seq #(.DATAWIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_imm     (in_imm),
        .in_rd      (in_rd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sub    (alu_sub),
        .alu_sum    (alu_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_illegal(out_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for a single accept edge; returns just after that edge
    task automatic send(input logic [1:0] op, input logic [W-1:0] s1, input logic [W-1:0] s2,
                        input logic [W-1:0] imm, input logic [4:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = s1;
        in_src2  = s2;
        in_imm   = imm;
        in_rd    = rd;
        tick();
        in_valid = 1'b0;
        in_src1  = '0;
        in_src2  = '0;
        in_imm   = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_src1   = '0;
        in_src2   = '0;
        in_imm    = '0;
        in_rd     = 5'd0;
        out_ready = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        check("rst_valid", W'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_rd", W'(out_rd), 0);
        check("rst_illegal", W'(out_illegal), 0);
        check("rst_in_ready", W'(in_ready), 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sub", W'(alu_sub), 0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", W'(in_ready), 1);

        // add 5+7, result visible two edges after accept
        send(2'b00, 32'd5, 32'd7, 32'd99, 5'd3);
        check("add_exec_valid", W'(out_valid), 0);
        check("add_exec_alu_a", alu_a, 32'd5);
        check("add_exec_alu_b", alu_b, 32'd7);
        check("add_exec_sub", W'(alu_sub), 0);
        check("add_exec_in_ready", W'(in_ready), 0);
        tick();
        check("add_valid", W'(out_valid), 1);
        check("add_data", out_data, 32'd12);
        check("add_rd", W'(out_rd), 32'd3);
        check("add_illegal", W'(out_illegal), 0);

        // Backpressure: stall in DONE for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", W'(out_valid), 1);
            check("bp_data", out_data, 32'd12);
            check("bp_in_ready", W'(in_ready), 0);
        end

        // Out handshake with in_valid already high: no accept in DONE
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_src1   = 32'd1;
        in_src2   = 32'd1;
        in_rd     = 5'd1;
        tick();
        check("hs_no_accept_ready", W'(in_ready), 1);
        check("hs_no_accept_valid", W'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        check("hs_next_accept", W'(in_ready), 0);
        tick();
        check("hs_next_data", out_data, 32'd2);
        check("hs_next_rd", W'(out_rd), 32'd1);
        tick();
        check("idle_after_hs", W'(in_ready), 1);

        // addi wraps to zero; src2 must be ignored
        send(2'b01, 32'hFFFF_FFFF, 32'h55, 32'd1, 5'd4);
        check("addi_alu_b", alu_b, 32'd1);
        tick();
        check("addi_data", out_data, 32'd0);
        check("addi_rd", W'(out_rd), 32'd4);
        tick();

        // sub wraps; alu_sub high only in EXEC
        send(2'b10, 32'd0, 32'd1, 32'd0, 5'd5);
        check("sub_exec_sub", W'(alu_sub), 1);
        tick();
        check("sub_data", out_data, 32'hFFFF_FFFF);
        check("sub_done_sub", W'(alu_sub), 0);
        tick();
        check("sub_idle_sub", W'(alu_sub), 0);

`ifdef EXU_SEQ_MUL_EN
        // mul 0x12345678 * 9
        send(2'b11, 32'h1234_5678, 32'h9, 32'd0, 5'd6);
        check("mul_first_a", alu_a, 32'd0);
        check("mul_first_b", alu_b, 32'h1234_5678);
        for (int i = 0; i < 31; i++) begin
            tick();
            check("mul_busy_valid", W'(out_valid), 0);
            check("mul_busy_sub", W'(alu_sub), 0);
        end
        tick();
        check("mul_valid", W'(out_valid), 1);
        check("mul_data", out_data, 32'hA3D7_0A38);
        check("mul_rd", W'(out_rd), 32'd6);
        tick();

        // all-ones squared
        send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd7);
        for (int i = 0; i < 32; i++) tick();
        check("mul_ones_valid", W'(out_valid), 1);
        check("mul_ones_data", out_data, 32'd1);
        tick();

        // Reset at MUL cycle 10 aborts the op
        send(2'b11, 32'd3, 32'd5, 32'd0, 5'd8);
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        check("mul_rst_valid", W'(out_valid), 0);
        check("mul_rst_in_ready", W'(in_ready), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("mul_abort_no_valid", W'(out_valid), 0);
        end
`else
        // op 11 is illegal without the multiplier
        send(2'b11, 32'd3, 32'd4, 32'd0, 5'd9);
        check("ill_valid", W'(out_valid), 1);
        check("ill_flag", W'(out_illegal), 1);
        check("ill_data", out_data, 32'd0);
        check("ill_rd", W'(out_rd), 32'd9);
        tick();
        check("ill_idle", W'(in_ready), 1);

        // Reset while a result is pending in DONE
        out_ready = 1'b0;
        send(2'b00, 32'd10, 32'd20, 32'd0, 5'd2);
        tick();
        check("pend_valid", W'(out_valid), 1);
        rst_n = 1'b0;
        tick();
        check("pend_rst_valid", W'(out_valid), 0);
        check("pend_rst_data", out_data, 32'd0);
        check("pend_rst_rd", W'(out_rd), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pend_no_valid", W'(out_valid), 0);
        end
`endif

        // Recovery after reset: 3+4
        send(2'b00, 32'd3, 32'd4, 32'd0, 5'd10);
        check("rec_exec_valid", W'(out_valid), 0);
        tick();
        check("rec_valid", W'(out_valid), 1);
        check("rec_data", out_data, 32'd7);
        check("rec_rd", W'(out_rd), 32'd10);
        check("rec_illegal", W'(out_illegal), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
